// File: rtl/alu_arbiter.sv
// Purpose: shares one 8-bit alu_all between two requesters (round-robin or fixed priority).
// Latency: accept in cycle T, rsp_valid from T+2; next accept no earlier than T+3.
// Backpressure: the response is held in RESP while rsp_ready=0; requests are refused until it drains.

module alu_all (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic [1:0] sel,
    output logic [7:0] out,
    output logic       cout
);
    // Subtract reports borrow in cout: bit 8 of the 9-bit difference is set when a-b-cin < 0.
    always_comb begin
        out  = '0;
        cout = 1'b0;
        case (sel)
            2'b00: {cout, out} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            2'b01: {cout, out} = {1'b0, a} - {1'b0, b} - {8'b0, cin};
            2'b10: out = a & b;
            2'b11: out = a | b;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int CNT_W     = 16,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic             req0_cin,
    input  logic [1:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic             req1_cin,
    input  logic [1:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_out,
    output logic             rsp_cout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic       id;
        logic [1:0] sel;
        logic       cin;
        logic [7:0] b;
        logic [7:0] a;
    } op_t;

    state_t state, state_nxt;
    op_t    op_q, op_sel;
    logic   last_grant;
    logic   gnt_vld, gnt_id;
    logic [7:0] alu_out;
    logic       alu_cout;

    // Ready is combinational from valid, so it is gated by reset and by the IDLE state.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (rst_n && state == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = FIXED_PRI ? 1'b0 : ~last_grant;
            end else if (req0_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_vld & ~gnt_id;
    assign req1_ready = gnt_vld &  gnt_id;

    always_comb begin
        op_sel = gnt_id ? op_t'{id: 1'b1, sel: req1_sel, cin: req1_cin, b: req1_b, a: req1_a}
                        : op_t'{id: 1'b0, sel: req0_sel, cin: req0_cin, b: req0_b, a: req0_a};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    alu_all u_alu (
        .a    (op_q.a),
        .b    (op_q.b),
        .cin  (op_q.cin),
        .sel  (op_q.sel),
        .out  (alu_out),
        .cout (alu_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= '0;
            rsp_id     <= 1'b0;
            rsp_out    <= '0;
            rsp_cout   <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_vld) begin
                op_q       <= op_sel;
                last_grant <= gnt_id;
            end
            if (state == EXEC) begin
                rsp_out  <= alu_out;
                rsp_cout <= alu_cout;
                rsp_id   <= op_q.id;
            end
            if (state == RESP && rsp_ready && op_count != {CNT_W{1'b1}})
                op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_alu_arbiter;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_sel, req1_sel;
    logic rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [7:0] rsp_out;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(CNT_W), .FIXED_PRI(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count)
    );

    // Reference ALU from plain integer arithmetic: returns {cout, out}.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic [1:0] sel);
        int r;
        logic [8:0] res;
        res = '0;
        case (sel)
            2'd0: begin r = int'(a) + int'(b) + int'(cin); res = {r > 255, 8'(r % 256)}; end
            2'd1: begin r = int'(a) - int'(b) - int'(cin); res = {r < 0, 8'((r + 512) % 256)}; end
            2'd2: res = {1'b0, a & b};
            default: res = {1'b0, a | b};
        endcase
        return res;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_a = 8'h12; req0_b = 8'h34; req0_cin = 1'b0; req0_sel = 2'd0;
        req1_a = 8'h56; req1_b = 8'h78; req1_cin = 1'b1; req1_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy} !== 6'b0 ||
                rsp_out !== 8'h00 || op_count !== '0) begin
                errors++;
                $display("FAIL reset cycle %0d: rdy=%b%b vld=%b id=%b cout=%b busy=%b out=%h cnt=%0d, required all 0",
                         i, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy, rsp_out, op_count);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        do_reset();
        req0_a = 8'hF0; req0_b = 8'h20; req0_cin = 1'b1; req0_sel = 2'b00;
        req0_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL add_accept: rdy=%b%b required 10", req0_ready, req1_ready);
        end
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL add_exec: vld=%b busy=%b required 0 1", rsp_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_out !== 8'h11 || rsp_cout !== 1'b1 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL add_resp: vld=%b out=%h cout=%b id=%b required 1 11 1 0",
                     rsp_valid, rsp_out, rsp_cout, rsp_id);
        end
        @(negedge clk);
        checks++;
        if (op_count !== 2'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL add_count: cnt=%0d busy=%b required 1 0", op_count, busy);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        req0_a = 8'h0F; req0_b = 8'hF0; req0_cin = 1'b0; req0_sel = 2'b11;
        req1_a = 8'hCC; req1_b = 8'hAA; req1_cin = 1'b0; req1_sel = 2'b10;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic       eid;
            logic [7:0] eout;
            eid  = 1'(k % 2);
            eout = eid ? 8'h88 : 8'hFF;
            @(negedge clk);
            checks++;
            if (req0_ready !== !eid || req1_ready !== eid) begin
                errors++; $display("FAIL contention_grant %0d: rdy=%b%b required id %0d", k, req0_ready, req1_ready, eid);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_out !== eout) begin
                errors++;
                $display("FAIL contention_resp %0d: vld=%b id=%b out=%h required 1 %0d %h",
                         k, rsp_valid, rsp_id, rsp_out, eid, eout);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [8:0] exp;
        do_reset();
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cin = 1'($urandom); req1_sel = 2'b01;
        exp = ref_alu(req1_a, req1_b, req1_cin, req1_sel);
        req1_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1 req1_valid = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_cout, rsp_out} !== exp || rsp_id !== 1'b1 ||
                busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure %0d: vld=%b cout/out=%h id=%b busy=%b rdy=%b%b required 1 %h 1 1 00",
                         i, rsp_valid, {rsp_cout, rsp_out}, rsp_id, busy, req0_ready, req1_ready, exp);
            end
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== 2'd1) begin
            errors++; $display("FAIL backpressure_release: busy=%b vld=%b cnt=%0d required 0 0 1", busy, rsp_valid, op_count);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        req1_a = 8'h33; req1_b = 8'h44; req1_cin = 1'b0; req1_sel = 2'b00;
        req1_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req1_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || op_count !== '0 || busy !== 1'b0) begin
                errors++; $display("FAIL reset_mid_exec %0d: vld=%b cnt=%0d busy=%b required 0 0 0", i, rsp_valid, op_count, busy);
            end
        end
        rsp_ready = 1'b0;
    endtask

    // Randomized traffic: a losing requester holds its operation until granted; op_count saturates at 3.
    task automatic test_random_saturation(input int n);
        bit v0 = 0, v1 = 0;
        int lg = 1, exp_cnt = 0, win, d;
        logic [8:0] exp;
        do_reset();
        for (int k = 0; k < n; k++) begin
            if (!v0 && $urandom_range(0, 2) != 0) begin
                v0 = 1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cin = 1'($urandom); req0_sel = 2'($urandom);
            end
            if (!v1 && ($urandom_range(0, 2) != 0 || !v0)) begin
                v1 = 1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cin = 1'($urandom); req1_sel = 2'($urandom);
            end
            req0_valid = v0; req1_valid = v1; rsp_ready = 1'b0;
            win = (v0 && v1) ? (lg == 1 ? 0 : 1) : (v0 ? 0 : 1);
            exp = win ? ref_alu(req1_a, req1_b, req1_cin, req1_sel) : ref_alu(req0_a, req0_b, req0_cin, req0_sel);
            @(negedge clk);
            checks++;
            if (op_count !== CNT_W'(exp_cnt) || req0_ready !== (win == 0) || req1_ready !== (win == 1)) begin
                errors++;
                $display("FAIL random_grant %0d: cnt=%0d rdy=%b%b required cnt %0d grant %0d",
                         k, op_count, req0_ready, req1_ready, exp_cnt, win);
            end
            @(posedge clk); #1;
            lg = win;
            if (win == 0) v0 = 0; else v1 = 0;
            req0_valid = v0; req1_valid = v1;
            @(posedge clk); #1;
            d = $urandom_range(0, 3);
            for (int j = 0; j <= d; j++) begin
                if (j == d) rsp_ready = 1'b1;
                @(negedge clk);
                checks++;
                if (rsp_valid !== 1'b1 || {rsp_cout, rsp_out} !== exp || rsp_id !== 1'(win) ||
                    req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL random_resp %0d.%0d: vld=%b cout/out=%h id=%b rdy=%b%b required 1 %h %0d 00",
                             k, j, rsp_valid, {rsp_cout, rsp_out}, rsp_id, req0_ready, req1_ready, exp, win);
                end
                @(posedge clk); #1;
            end
            rsp_ready = 1'b0;
            if (exp_cnt < 3) exp_cnt++;
        end
        @(negedge clk);
        checks++;
        if (op_count !== CNT_W'(exp_cnt)) begin
            errors++; $display("FAIL random_final_count: cnt=%0d required %0d", op_count, exp_cnt);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sel = '0;
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_reset_mid_exec();
        test_random_saturation(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares one 8-bit `alu_all` (add, subtract, AND, OR) between two requesters. It accepts one operation at a time over a valid/ready handshake and picks between simultaneous requesters round-robin. It registers the operands, captures the ALU result and returns it with the requester ID over a valid/ready response channel. It sits between the instruction-issue logic and the ALU datapath, and instantiates `alu_all` internally.

## Interface
- `CNT_W`, 16: width of the completed-operation counter `op_count`.
- `FIXED_PRI`, 0: 0 selects round-robin; 1 selects fixed priority, where requester 0 always wins.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req0_valid` / `req1_valid` input 1: the requester has an operation pending.
- `req0_ready` / `req1_ready` output 1: the operation is accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` input 8: operands.
- `req0_cin` / `req1_cin` input 1: carry/borrow in.
- `req0_sel` / `req1_sel` input 2: ALU op; 00 add, 01 subtract, 10 AND, 11 OR.
- `rsp_valid` output 1: a result is available.
- `rsp_ready` input 1: the consumer takes the result.
- `rsp_id` output 1: the requester that issued the result.
- `rsp_out` output 8: ALU result.
- `rsp_cout` output 1: ALU carry/borrow out, passed unmodified from `alu_all`.
- `busy` output 1: high whenever the state is not IDLE.
- `op_count` output CNT_W: completed responses, saturating.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any `reqN_valid` is high, grant exactly one requester.
  - Assert its `reqN_ready` combinationally in the same cycle.
  - Latch its a, b, cin, sel and ID into the operand registers.
  - Go to EXEC.
- **EXEC:**
  - `alu_all` is driven from the operand registers.
  - `out` and `cout` are captured into `rsp_out` / `rsp_cout`.
  - Go to RESP.
- **RESP:**
  - `rsp_valid` = 1.
  - `rsp_out`, `rsp_cout` and `rsp_id` are held stable until `rsp_valid & rsp_ready`.
  - On that handshake: `op_count` increments, saturating at 2^CNT_W−1, and the FSM returns to IDLE.
- Requests are accepted only in IDLE. `reqN_ready` is 0 in EXEC and RESP.
- Requesters hold valid and operands stable until ready. A request that is not granted is neither dropped nor latched.
- Round-robin:
  - The `last_grant` register resets to 1, so requester 0 wins the first contention.
  - When both requesters are valid, the one not equal to `last_grant` wins.
  - With only one valid, that requester wins regardless of `last_grant`.
  - `last_grant` updates on every grant.
- With `FIXED_PRI`=1, requester 0 wins whenever it is valid. `last_grant` is ignored.
- The block applies no arithmetic of its own. Result and flags are exactly what `alu_all` produces for the latched operands.

## Timing
- Reset values:
  - FSM state IDLE; `last_grant` 1.
  - `rsp_valid`, `rsp_id`, `rsp_out`, `rsp_cout`, `busy`, `op_count` all 0.
  - `req0_ready` and `req1_ready` 0 while `rst_n`=0.
- Latency: request accepted in cycle T gives `rsp_valid`=1 from cycle T+2.
- Minimum spacing between accepts is 3 cycles: accept, EXEC, RESP with `rsp_ready`=1. The next accept is no earlier than T+3.
- Backpressure: with `rsp_ready`=0 the FSM stays in RESP indefinitely and all `rsp_*` outputs stay constant.
- Reset asserted in any state:
  - Returns to the reset values on the next edge.
  - An operation in flight is discarded; no response is produced and `op_count` is not incremented.
- A `reqN_valid` that drops before it is granted causes no action.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with both valids high.
  - All outputs read 0 and neither ready asserts.
- **Single add:** req0 with a=8'hF0, b=8'h20, cin=1, sel=00, `rsp_ready`=1.
  - `req0_ready` is high in the accept cycle T.
  - At T+2: `rsp_valid`=1, `rsp_out`=8'h11, `rsp_cout`=1, `rsp_id`=0.
  - `op_count`=1 after the handshake.
- **Contention:** req0 holds sel=11 with a=8'h0F, b=8'hF0. req1 holds sel=10 with a=8'hCC, b=8'hAA. Both are valid continuously.
  - First response: id 0, out 8'hFF.
  - Second response: id 1, out 8'h88.
  - Grants then alternate 0, 1, 0, 1.
- **Backpressure:** keep `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - `rsp_*` outputs are stable and both readies stay 0.
  - `busy`=1 throughout.
  - Raising `rsp_ready` completes the handshake; the FSM is back in IDLE on the next edge.
- **Reset mid-EXEC:** accept a req1 operation, then pull `rst_n` low on the following cycle.
  - `rsp_valid` never rises and `op_count` stays 0.
- **Saturation:** with `CNT_W`=2, complete 5 operations.
  - `op_count` reads 1, 2, 3, 3, 3.
